// File: rtl/replication_xor_decoder.sv
// Receive-side decoder/checker for replication_xor pairwise-XNOR vectors.
// Rebuilds {a,b,c,d,e} from row 0 and scans all 25 pair bits against it.
//
// state | meaning
// IDLE  | ready for a vector, outputs hold last result
// CHECK | one pair bit compared per cycle, pairs 0..24
// DONE  | result presented until out_ready
module replication_xor_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [24:0] in_vec,
  input  logic        in_pol,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [4:0]  out_word,
  output logic        out_err,
  output logic [4:0]  out_err_cnt,
  output logic [4:0]  out_err_idx,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state, state_nxt;
  logic [24:0] vec_q;
  logic [2:0]  row_q;
  logic [2:0]  col_q;
  logic [4:0]  idx_q;
  logic [4:0]  word_in;
  logic [2:0]  row_sel;
  logic [2:0]  col_sel;
  logic        last_pair;
  logic        pair_bad;

  // Row 0 bit (0,j) is ~(a ^ xj), so xj = a ^ ~bit; bit (0,0) only gets checked.
  assign word_in   = {in_pol, {4{in_pol}} ^ ~in_vec[23:20]};
  assign row_sel   = 3'd4 - row_q;
  assign col_sel   = 3'd4 - col_q;
  assign last_pair = (idx_q == 5'd24);
  // vec_q shifts left so the pair under test is always at bit 24.
  assign pair_bad  = vec_q[24] != ~(out_word[row_sel] ^ out_word[col_sel]);

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = CHECK;
      CHECK:   if (last_pair) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      idx_q       <= '0;
      out_word    <= '0;
      out_err     <= 1'b0;
      out_err_cnt <= '0;
      out_err_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            vec_q       <= in_vec;
            out_word    <= word_in;
            out_err     <= 1'b0;
            out_err_cnt <= '0;
            out_err_idx <= '0;
            row_q       <= '0;
            col_q       <= '0;
            idx_q       <= '0;
          end
        end
        CHECK: begin
          vec_q <= {vec_q[23:0], 1'b0};
          idx_q <= idx_q + 5'd1;
          if (col_q == 3'd4) begin
            col_q <= '0;
            row_q <= row_q + 3'd1;
          end else begin
            col_q <= col_q + 3'd1;
          end
          if (pair_bad) begin
            out_err_cnt <= out_err_cnt + 5'd1;
            if (!out_err) begin
              out_err     <= 1'b1;
              out_err_idx <= idx_q;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/replication_xor_decoder.md
# replication_xor_decoder

Sequential decoder and checker for the 25-bit pairwise-XNOR vector produced by `replication_xor`. It accepts one vector over a valid/ready handshake and reconstructs the 5-bit source word `{a,b,c,d,e}` up to a polarity chosen by the caller. It then scans all 25 pair bits, one per cycle, against the reconstruction and reports mismatches. It sits on the receive side of any path carrying `replication_xor` output, and flags corrupted or non-encodable vectors.

## Interface
- No parameters; widths fixed by the encoding (5 sources, 25 pair bits).
- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_vec`  input  25  encoded vector.
- `in_pol`  input  1  assumed value of source `a`, sampled with `in_vec`.
- `in_valid`  input  1  `in_vec`/`in_pol` valid.
- `in_ready`  output  1  block can accept a vector.
- `out_word`  output  5  decoded `{a,b,c,d,e}`, `a` is MSB.
- `out_err`  output  1  at least one pair bit is inconsistent.
- `out_err_cnt`  output  5  number of mismatching pair bits, range 0..25.
- `out_err_idx`  output  5  row-major index (5*i+j) of the first mismatch; 0 when `out_err`=0.
- `out_valid`  output  1  result valid.
- `out_ready`  input  1  consumer accepts the result.

## Operation
- **Encoding.** Sources are x0..x4 = a..e. Pair bit (i,j) = ~(xi ^ xj) sits at `in_vec[24-(5*i+j)]`. Bit 24 is pair (0,0); bit 0 is pair (4,4).
- **Reconstruction.** x0 = `in_pol`. For j=1..4, xj = `in_pol` ^ ~bit(0,j). Bit (0,0) is not used for reconstruction; it is only checked.
- **IDLE state.**
  - `in_ready`=1 and `out_valid`=0.
  - On `in_valid`&&`in_ready`, latch `in_vec`, compute and register the candidate word, clear the error registers, set the index counter to 0, and go to CHECK.
- **CHECK state.**
  - `in_ready`=0 and `out_valid`=0.
  - Each cycle, evaluate pair k=5*i+j, where k is the counter value:
    - expected = ~(xi ^ xj); compare it with the latched bit.
    - On mismatch, increment `err_cnt`.
    - If this is the first mismatch, record k into `err_idx` and set `err`.
  - When k=24 is evaluated, go to DONE.
  - The scan always runs all 25 pairs, so latency is fixed. There is no early exit on error.
- **DONE state.**
  - `out_valid`=1 and `in_ready`=0.
  - All `out_*` outputs are held stable until `out_valid`&&`out_ready`.
  - On that handshake, return to IDLE.
  - No new input is accepted in DONE; a vector presented there waits.
- **Data outputs** are registered. They hold their last value outside DONE; consumers sample them only while `out_valid`=1.
- **Arithmetic.** `err_cnt` is 5 bits and saturation is never needed, since the maximum is 25. The counter range is 0..24 and never wraps mid-scan.
- **Reset.**
  - Applies in any state, including mid-CHECK or DONE with `out_ready`=0.
  - Next state is IDLE; any in-flight vector is discarded.
  - All outputs take their reset values: `in_ready`=1, `out_valid`=0, `out_word`=0, `out_err`=0, `out_err_cnt`=0, `out_err_idx`=0.
  - Reset has priority over a simultaneous `in_valid` or `out_ready`.

## Timing
- **Input handshake.** A vector is accepted at rising edge T when `in_valid`=1 and `in_ready`=1. `in_ready` is 0 from after edge T.
- **Scan.** Edges T+1 .. T+25 evaluate pairs 0..24.
- **Result.** `out_valid`=1 from after edge T+25, giving a latency of 25 cycles from acceptance to result.
- **Output handshake.** A result handshake at edge R gives `out_valid`=0 and `in_ready`=1 after R.
  - The next vector can be accepted at edge R+1 at the earliest.
  - Peak throughput is 1 vector per 27 cycles.
- **`in_ready`** depends only on state, not combinationally on `in_valid` or `out_ready`.
- **`out_ready` held low.** Indefinite stall in DONE; outputs stay constant.

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `in_valid`=1 -> all outputs at reset values; `in_ready`=1; nothing accepted during reset.
- **All-zero source.** `in_vec`=25'h1FFFFFF (source 00000), `in_pol`=0 -> 25 cycles later `out_word`=5'b00000, `out_err`=0, `out_err_cnt`=0, `out_err_idx`=0.
- **Polarity.** `in_vec`=25'h1363273 (source 10011):
  - with `in_pol`=1 -> `out_word`=5'b10011, `out_err`=0;
  - with `in_pol`=0 -> `out_word`=5'b01100, `out_err`=0.
- **Single-bit corruption.** `in_pol`=1:
  - 25'h1363272 (pair (4,4) flipped) -> `out_word`=10011, `out_err`=1, `out_err_cnt`=1, `out_err_idx`=24;
  - 25'h0363273 (pair (0,0) flipped) -> `out_word`=10011, `out_err_cnt`=1, `out_err_idx`=0.
- **Back-pressure.** Hold `out_ready`=0 for 10 cycles after `out_valid` rises -> outputs constant, `in_ready`=0, a second pending `in_valid` not accepted. Then raise `out_ready` -> second vector accepted exactly one cycle after the result handshake.
- **Reset mid-scan.** Assert `rst` 10 cycles into CHECK -> IDLE next cycle, `out_valid` never rises for that vector. A subsequent 25'h1FFFFFF decodes to 00000 with `out_err_cnt`=0.
